fifo_stream_drain: RTL
======================

// Module: fifo_stream_drain
// PURPOSE
//  Downstream consumer of synchronous_fifo. Turns the FIFO read side (rd_en / data_out / empty)
//  into a valid/ready stream that can take backpressure. Hides the FIFO's 1-cycle read latency
//  with a small registered buffer, and marks frame boundaries with m_last every PKT_LEN beats.
// PARAMETERS
//  DATA_W     8    width of FIFO data and stream data
//  BUF_DEPTH  3    entries in the output buffer; min 2; 3 is needed for 1 beat/cycle
//  PKT_LEN    4    beats per frame; min 1
//  FCNT_W     16   width of the completed-frame counter
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  fifo_empty  in   1       FIFO empty flag
//  fifo_data   in   DATA_W  FIFO data_out; valid the cycle after a sampled fifo_rd_en
//  fifo_rd_en  out  1       read request to the FIFO
//  m_valid     out  1       stream data valid
//  m_ready     in   1       downstream ready
//  m_data      out  DATA_W  stream data
//  m_last      out  1       last beat of the current frame
//  frame_cnt   out  FCNT_W  number of completed frames; wraps
// BEHAVIOUR
//  - Reset (async assert, sync release): buffer empty, in-flight flag 0, beat counter 0,
//    frame_cnt 0, m_valid 0, m_data 0, m_last 0, fifo_rd_en 0.
//    An in-flight read at reset is discarded; the FIFO is reset by the same rst.
//  - Read issue: fifo_rd_en = !fifo_empty && (occ + inflight < BUF_DEPTH).
//    Built combinationally from registered state only. No combinational path from m_ready.
//    fifo_rd_en is never 1 while fifo_empty = 1.
//  - inflight: registered copy of fifo_rd_en. When inflight = 1, fifo_data is written into
//    the buffer at that clock edge.
//  - Buffer: circular, with wr_ptr/rd_ptr mod BUF_DEPTH; occ runs 0..BUF_DEPTH.
//    Push and pop in the same cycle leave occ unchanged. The credit rule makes overflow impossible.
//  - Latency: fifo_empty seen low in cycle T -> rd_en in T -> m_valid=1 in T+2.
//    Steady state is 1 beat/cycle when BUF_DEPTH >= 3 and m_ready = 1.
//  - Handshake: a beat transfers when m_valid && m_ready.
//    While m_valid && !m_ready, m_data and m_last hold stable and m_valid stays 1.
//    m_valid = (occ != 0). m_data is the head entry.
//  - Framing: beat_cnt (0..PKT_LEN-1) advances on each handshake and wraps to 0 after PKT_LEN-1.
//    m_last = m_valid && (beat_cnt == PKT_LEN-1).
//    frame_cnt increments on a handshake with m_last, and wraps at 2**FCNT_W.
//    PKT_LEN = 1 sets m_last on every beat.
//  - Ordering: bytes leave in exactly FIFO order, with no loss and no duplication.
//  - A FIFO that empties mid-frame only stalls the stream; frame position is kept.
// STRUCTURE
//  - Package fifo_stream_pkg: typedef logic [7:0] byte_t; localparam DEF_BUF_DEPTH=3,
//    DEF_PKT_LEN=4, FIFO_RD_LAT=1.
//  - Sub-module stream_skid_buf: circular buffer with push, pop, occ, head data.
//  - Top level: credit/read-issue logic, in-flight register, beat/frame counters.
//  - Bench instantiates synchronous_fifo (DEPTH 4) feeding fifo_stream_drain.
// TESTING
//  1. Write 0x11,0x22,0x33,0x44 into the FIFO; m_ready=1
//     -> m_data 11,22,33,44 on 4 consecutive cycles; m_last only with 0x44; frame_cnt=1.
//  2. FIFO holds 4 bytes, m_ready=0 for 10 cycles
//     -> exactly 3 rd_en pulses; m_valid=1; m_data held at 0x11. After m_ready=1, all 4 bytes in order.
//  3. Write 8 bytes with the FIFO kept fed; PKT_LEN=4
//     -> m_last on beats 4 and 8; frame_cnt=2.
//  4. FIFO empty for 20 cycles
//     -> fifo_rd_en=0 and m_valid=0 on every cycle.
//  5. rst pulsed mid-cycle after 2 beats of a frame
//     -> all outputs 0 immediately. After release, the next frame's m_last is on the 4th beat.
//  6. 64 random bytes, writes and m_ready each toggled at 50%
//     -> scoreboard matches order exactly; no rd_en while empty; m_data stable under stall.

Source files
------------

// File: rtl/fifo_stream_pkg.sv
// Shared types and defaults for the FIFO-to-stream drain slice.
package fifo_stream_pkg;

  typedef logic [7:0] byte_t;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_BUF_DEPTH = 3;
  localparam int unsigned DEF_PKT_LEN   = 4;
  localparam int unsigned DEF_FCNT_W    = 16;
  localparam int unsigned FIFO_RD_LAT   = 1;

  // Bits needed to hold any value in 0..max_val (at least 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Small circular buffer that absorbs the FIFO read latency ahead of the stream port.
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_BUF_DEPTH,
  localparam int unsigned OCC_W = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [OCC_W-1:0]  occ,
  output logic [DATA_W-1:0] head_data
);

  localparam int unsigned PTR_W = cnt_width(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign occ       = occ_q;
  assign head_data = mem_q[rd_ptr_q];

  // Next-state: caller guarantees no push when full and no pop when empty.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // State registers; entries clear on reset so the idle head reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/synchronous_fifo.sv
// Single-clock FIFO with a registered read port (data_out valid the cycle after rd_en).
module synchronous_fifo
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = cnt_width(DEPTH - 1);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              do_wr, do_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign data_out = data_out_q;

  // Next-state: writes ignored when full, reads ignored when empty.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    do_wr      = wr_en && !full;
    do_rd      = rd_en && !empty;
    if (do_wr) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_rd) begin
      data_out_d = mem_q[rd_ptr_q];
      rd_ptr_d   = ptr_inc(rd_ptr_q);
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end

endmodule

// File: rtl/fifo_stream_drain.sv
// Drains a synchronous FIFO into a valid/ready stream with frame markers and a frame counter.
module fifo_stream_drain
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int unsigned PKT_LEN   = DEF_PKT_LEN,
  parameter int unsigned FCNT_W    = DEF_FCNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int unsigned OCC_W  = cnt_width(BUF_DEPTH);
  localparam int unsigned FILL_W = OCC_W + 1;
  localparam int unsigned BEAT_W = cnt_width(PKT_LEN - 1);

  logic [OCC_W-1:0]  occ;
  logic [DATA_W-1:0] head_data;
  logic [FILL_W-1:0] fill;
  logic              handshake;
  logic              inflight_q, inflight_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  stream_skid_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (fifo_data),
    .pop       (handshake),
    .occ       (occ),
    .head_data (head_data)
  );

  // Stream outputs and read credit, all from registered state (no m_ready path into rd_en).
  always_comb begin
    fill       = FILL_W'(occ) + FILL_W'(inflight_q);
    fifo_rd_en = !fifo_empty && (fill < FILL_W'(BUF_DEPTH));
    m_valid    = (occ != '0);
    m_data     = head_data;
    m_last     = m_valid && (beat_cnt_q == BEAT_W'(PKT_LEN - 1));
    handshake  = m_valid && m_ready;
    frame_cnt  = frame_cnt_q;
  end

  // Next-state for in-flight flag and beat/frame counters.
  always_comb begin
    inflight_d  = fifo_rd_en;
    beat_cnt_d  = beat_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (handshake) begin
      if (m_last) begin
        beat_cnt_d  = '0;
        frame_cnt_d = frame_cnt_q + FCNT_W'(1);
      end else begin
        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
      end
    end
  end

  // State registers; a read in flight at reset is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q  <= 1'b0;
      beat_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      inflight_q  <= inflight_d;
      beat_cnt_q  <= beat_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule
